// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: drains NUM_FIFOS input FIFOs into one output FIFO.
// Also programs the almost-full/almost-empty thresholds from an INIT state and
// holds a sticky ERROR state when any input FIFO reports an error.
module fifo_rr_scheduler #(
  parameter int BITNUMBER = 8,
  parameter int NUM_FIFOS = 4,
  parameter int PTR_W     = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [PTR_W-1:0]               umbral_af_in,
  input  logic [PTR_W-1:0]               umbral_ae_in,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS-1:0]           fifo_error,
  input  logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data,
  input  logic                           out_almost_full,
  output logic [NUM_FIFOS-1:0]           fifo_rd,
  output logic                           out_wr,
  output logic [BITNUMBER-1:0]           out_data,
  output logic [PTR_W-1:0]               umbral_af_out,
  output logic [PTR_W-1:0]               umbral_ae_out,
  output logic [2:0]                     state,
  output logic                           idle,
  output logic                           error_out
);

  localparam int RR_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [RR_W-1:0]       rr_ptr;
  logic [RR_W-1:0]       winner_q;
  logic [RR_W-1:0]       winner_d;
  logic [RR_W-1:0]       search_idx;
  logic                  found;
  logic                  grant_d;
  logic                  in_flight;
  logic [NUM_FIFOS-1:0]  grant_onehot;
  logic                  any_error;
  logic                  all_empty;

  assign any_error = |fifo_error;
  assign all_empty = &fifo_empty;

  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

  // State register; reset always wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an error from any FIFO overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (any_error) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (init)            state_d = ST_INIT;
          else if (!all_empty) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                         state_d = ST_INIT;
          else if (all_empty && !in_flight) state_d = ST_IDLE;
        end
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_RESET;
      endcase
    end
  end

  // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    found      = 1'b0;
    winner_d   = '0;
    search_idx = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      search_idx = rr_ptr + RR_W'(i);
      if (!found && !fifo_empty[search_idx]) begin
        found    = 1'b1;
        winner_d = search_idx;
      end
    end
  end

  // A grant is only issued while the FSM stays in ACTIVE across this edge,
  // so fifo_rd can never be seen high outside ACTIVE.
  always_comb begin
    grant_d      = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) &&
                   !out_almost_full && found;
    grant_onehot = '0;
    if (grant_d) begin
      grant_onehot = NUM_FIFOS'(1) << winner_d;
    end
  end

  // Read strobe, one-cycle-later output write, pointer update and threshold latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_rd       <= '0;
      out_wr        <= 1'b0;
      out_data      <= '0;
      rr_ptr        <= '0;
      winner_q      <= '0;
      in_flight     <= 1'b0;
      umbral_af_out <= '0;
      umbral_ae_out <= '0;
    end else begin
      if (state_d == ST_ERROR) begin
        // Entering or sitting in ERROR discards any pending word.
        fifo_rd   <= '0;
        out_wr    <= 1'b0;
        in_flight <= 1'b0;
      end else begin
        // The pending word is written regardless of a move to INIT.
        out_wr <= in_flight;
        if (in_flight) begin
          out_data <= fifo_data[int'(winner_q)*BITNUMBER +: BITNUMBER];
        end
        in_flight <= grant_d;
        fifo_rd   <= grant_onehot;
        if (grant_d) begin
          winner_q <= winner_d;
          rr_ptr   <= winner_d + RR_W'(1);
        end
      end
      if (state_q == ST_INIT) begin
        umbral_af_out <= umbral_af_in;
        umbral_ae_out <= umbral_ae_in;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the scheduler.
module tb_fifo_rr_scheduler;

  localparam int BW = 8;
  localparam int NF = 4;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [PW-1:0]     umbral_af_in;
  logic [PW-1:0]     umbral_ae_in;
  logic [NF-1:0]     fifo_empty;
  logic [NF-1:0]     fifo_error;
  logic [NF*BW-1:0]  fifo_data;
  logic              out_almost_full;
  logic [NF-1:0]     fifo_rd;
  logic              out_wr;
  logic [BW-1:0]     out_data;
  logic [PW-1:0]     umbral_af_out;
  logic [PW-1:0]     umbral_ae_out;
  logic [2:0]        state;
  logic              idle;
  logic              error_out;

  fifo_rr_scheduler #(.BITNUMBER(BW), .NUM_FIFOS(NF), .PTR_W(PW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
    .out_almost_full(out_almost_full),
    .fifo_rd(fifo_rd), .out_wr(out_wr), .out_data(out_data),
    .umbral_af_out(umbral_af_out), .umbral_ae_out(umbral_ae_out),
    .state(state), .idle(idle), .error_out(error_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: plain integers; m_rd is the index granted last edge, -1 if none.
  bit model_valid = 0;
  int m_state, m_ptr, m_rd, m_wr, m_data, m_af, m_ae;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slice(input logic [NF*BW-1:0] d, input int idx);
    logic [BW-1:0] w;
    w = d[idx*BW +: BW];
    return int'(w);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int nst, w;
    if (!reset) begin
      m_state = 0; m_ptr = 0; m_rd = -1; m_wr = 0; m_data = 0; m_af = 0; m_ae = 0;
      model_valid = 1;
      return;
    end
    if (fifo_error != 0) nst = 4;
    else begin
      case (m_state)
        0: nst = 1;
        1: nst = init ? 1 : 2;
        2: nst = init ? 1 : ((fifo_empty != '1) ? 3 : 2);
        3: nst = init ? 1 : ((fifo_empty == '1 && m_rd < 0) ? 2 : 3);
        default: nst = 4;
      endcase
    end
    if (m_state == 1) begin
      m_af = int'(umbral_af_in);
      m_ae = int'(umbral_ae_in);
    end
    if (nst == 4) begin
      m_wr = 0;
      m_rd = -1;
    end else begin
      m_wr = (m_rd >= 0) ? 1 : 0;
      if (m_rd >= 0) m_data = slice(fifo_data, m_rd);
      m_rd = -1;
      if (m_state == 3 && nst == 3 && !out_almost_full) begin
        for (int k = 0; k < NF; k++) begin
          w = (m_ptr + k) % NF;
          if (m_rd < 0 && !fifo_empty[w]) m_rd = w;
        end
        if (m_rd >= 0) m_ptr = (m_rd + 1) % NF;
      end
    end
    m_state = nst;
  endtask

  task automatic compare_all();
    if (!model_valid) return;
    chk("state", 32'(state), 32'(m_state));
    chk("idle", 32'(idle), 32'(m_state == 2));
    chk("error_out", 32'(error_out), 32'(m_state == 4));
    chk("fifo_rd", 32'(fifo_rd), (m_rd >= 0) ? (32'd1 << m_rd) : 32'd0);
    chk("out_wr", 32'(out_wr), 32'(m_wr));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("umbral_af_out", 32'(umbral_af_out), 32'(m_af));
    chk("umbral_ae_out", 32'(umbral_ae_out), 32'(m_ae));
  endtask

  // One clock: update the model at the edge, compare shortly after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  logic [NF-1:0] exp_rd [4];

  initial begin
    exp_rd[0] = 4'b0001; exp_rd[1] = 4'b0010; exp_rd[2] = 4'b0100; exp_rd[3] = 4'b1000;
    reset = 0; init = 0; umbral_af_in = '0; umbral_ae_in = '0;
    fifo_empty = '1; fifo_error = '0; fifo_data = '0; out_almost_full = 0;

    // Reset, INIT, threshold programming.
    tick(); tick();
    chk("lit_reset_state", 32'(state), 32'd0);
    chk("lit_reset_rd", 32'(fifo_rd), 32'd0);
    reset = 1; init = 1; umbral_af_in = 3'd6; umbral_ae_in = 3'd2;
    tick();
    chk("lit_init_state", 32'(state), 32'd1);
    tick();
    init = 0;
    tick();
    chk("lit_idle_state", 32'(state), 32'd2);
    chk("lit_af", 32'(umbral_af_out), 32'd6);
    chk("lit_ae", 32'(umbral_ae_out), 32'd2);

    // All FIFOs non-empty: strict rotation, write one cycle behind each grant.
    fifo_empty = 4'b0000;
    fifo_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    chk("lit_active", 32'(state), 32'd3);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("lit_rr_rd", 32'(fifo_rd), 32'(exp_rd[k % 4]));
      if (k >= 1) begin
        chk("lit_rr_wr", 32'(out_wr), 32'd1);
        chk("lit_rr_data", 32'(out_data), 32'h11 * 32'((k - 1) % 4 + 1));
      end
    end

    // Single non-empty FIFO gets every grant.
    fifo_empty = 4'b1011;
    fifo_data[23:16] = 8'hA5;
    tick();
    tick();
    chk("lit_single_rd", 32'(fifo_rd), 32'h4);
    chk("lit_single_data", 32'(out_data), 32'hA5);
    tick();
    chk("lit_single_rd2", 32'(fifo_rd), 32'h4);
    chk("lit_single_wr2", 32'(out_wr), 32'd1);

    // Backpressure: no new grant, one trailing write, resume after release.
    out_almost_full = 1;
    tick();
    chk("lit_bp_rd", 32'(fifo_rd), 32'd0);
    chk("lit_bp_wr", 32'(out_wr), 32'd1);
    tick();
    chk("lit_bp_wr2", 32'(out_wr), 32'd0);
    out_almost_full = 0;
    tick();
    chk("lit_bp_resume", 32'(fifo_rd), 32'h4);

    // Error is sticky until reset.
    fifo_error = 4'b0010;
    tick();
    chk("lit_err_state", 32'(state), 32'd4);
    chk("lit_err_rd", 32'(fifo_rd), 32'd0);
    chk("lit_err_wr", 32'(out_wr), 32'd0);
    fifo_error = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_err_sticky", 32'(state), 32'd4);
    end

    // Reset right after a grant drops the pending word and rewinds the pointer.
    reset = 0; tick();
    reset = 1; fifo_empty = 4'b0000; fifo_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick(); tick(); tick(); tick();
    chk("lit_pre_rst_rd", 32'(fifo_rd), 32'h2);
    reset = 0;
    tick();
    chk("lit_midrst_state", 32'(state), 32'd0);
    chk("lit_midrst_wr", 32'(out_wr), 32'd0);
    reset = 1;
    tick(); tick(); tick(); tick();
    chk("lit_ptr_rewind", 32'(fifo_rd), 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 99) < ((m_state == 4) ? 20 : 2)) ? 1'b0 : 1'b1;
      init            = ($urandom_range(0, 29) == 0);
      fifo_error      = ($urandom_range(0, 119) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
      fifo_empty      = ($urandom_range(0, 5) == 0) ? '1 : NF'($urandom);
      fifo_data       = $urandom;
      out_almost_full = ($urandom_range(0, 3) == 0);
      umbral_af_in    = PW'($urandom);
      umbral_ae_in    = PW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
